// File: rtl/axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb.sv
// axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb: N-channel AXIS packet arbiter/mux with CH0 priority, weighted RR and link-down flush
module axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb #(
  parameter int    C_DATA_WIDTH   = 64,
  parameter int    C_NUM_CH       = 4,
  parameter string C_PRIO_CH0     = "TRUE",
  parameter int    C_WEIGHT_WIDTH = 4,
  parameter int    TCQ            = 1,
  parameter int    STRB_WIDTH     = C_DATA_WIDTH / 8,
  parameter int    CH_W           = $clog2(C_NUM_CH)
) (
  input  logic                                 com_iclk,
  input  logic                                 com_sysrst_n,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_CH-1:0]                  s_axis_tvalid,
  output logic [C_NUM_CH-1:0]                  s_axis_tready,
  input  logic [C_NUM_CH*STRB_WIDTH-1:0]       s_axis_tstrb,
  input  logic [C_NUM_CH-1:0]                  s_axis_tlast,
  input  logic [C_NUM_CH*4-1:0]                s_axis_tuser,
  input  logic [C_NUM_CH*C_WEIGHT_WIDTH-1:0]   ch_weight,
  output logic [C_DATA_WIDTH-1:0]              m_axis_tx_tdata,
  output logic [STRB_WIDTH-1:0]                m_axis_tx_tstrb,
  output logic                                 m_axis_tx_tlast,
  output logic [3:0]                           m_axis_tx_tuser,
  output logic                                 m_axis_tx_tvalid,
  input  logic                                 m_axis_tx_tready,
  input  logic                                 trn_lnk_up,
  output logic [CH_W-1:0]                      channel_sel,
  output logic                                 in_packet,
  output logic                                 flush_axis_tlp
);
  localparam bit PRIO = (C_PRIO_CH0 == "TRUE");
  if (C_NUM_CH < 2 || C_NUM_CH > 8 || TCQ < 0 ||
      !(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128)) begin : g_bad_param
    $error("illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] sel, sel_n, last_grant, last_n, pick, idx;
  logic [C_WEIGHT_WIDTH-1:0] credit, credit_n, w;
  logic found, hs, sel_last;
  assign sel_last = s_axis_tlast[sel];
  assign hs = s_axis_tvalid[sel] & m_axis_tx_tready;
  // Round-robin scan starts just past the last RR owner and wraps back to it.
  always_comb begin
    found = 1'b0;
    pick = last_grant;
    idx = '0;
    for (int k = 1; k <= C_NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % C_NUM_CH);
      if (!found && s_axis_tvalid[idx] && !(PRIO && idx == '0)) begin
        found = 1'b1;
        pick = idx;
      end
    end
    w = ch_weight[pick*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH];
  end
  always_comb begin
    state_n = state;
    sel_n = sel;
    last_n = last_grant;
    credit_n = credit;
    case (state)
      IDLE:
        if (trn_lnk_up && |s_axis_tvalid) begin
          if (PRIO && s_axis_tvalid[0]) begin
            sel_n = '0;
            state_n = PKT;
          end else if (s_axis_tvalid[last_grant] && credit != '0) begin
            sel_n = last_grant;
            credit_n = credit - C_WEIGHT_WIDTH'(1);
            state_n = PKT;
          end else if (found) begin
            sel_n = pick;
            last_n = pick;
            credit_n = (w == '0) ? '0 : w - C_WEIGHT_WIDTH'(1);
            state_n = PKT;
          end
        end
      PKT:
        if (hs && sel_last) state_n = IDLE;
        else if (!trn_lnk_up) state_n = FLUSH;
      FLUSH:
        if (s_axis_tvalid[sel] && sel_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge com_iclk or negedge com_sysrst_n)
    if (!com_sysrst_n) begin
      state <= IDLE;
      sel <= '0;
      last_grant <= CH_W'(C_NUM_CH - 1);
      credit <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      last_grant <= last_n;
      credit <= credit_n;
    end
  assign channel_sel = sel;
  assign in_packet = (state != IDLE);
  assign flush_axis_tlp = (state == FLUSH);
  assign m_axis_tx_tvalid = (state == PKT) && s_axis_tvalid[sel];
  assign m_axis_tx_tdata = (state == PKT) ? s_axis_tdata[sel*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
  assign m_axis_tx_tstrb = (state == PKT) ? s_axis_tstrb[sel*STRB_WIDTH +: STRB_WIDTH] : '0;
  assign m_axis_tx_tuser = (state == PKT) ? s_axis_tuser[sel*4 +: 4] : '0;
  assign m_axis_tx_tlast = (state == PKT) && sel_last;
  // Flush drains the granted channel unconditionally so the truncated TLP is discarded.
  assign s_axis_tready = (state == PKT)   ? C_NUM_CH'(m_axis_tx_tready) << sel :
                         (state == FLUSH) ? C_NUM_CH'(1) << sel : '0;
endmodule

// File: tb/tb_axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb.sv
// tb_axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb: directed tests of grant order, priority, flush and backpressure
module tb_axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb;
  localparam int W = 64, N = 4, SW = 8;
  logic clk = 1'b0, rst_n;
  logic [N*W-1:0] tdata;
  logic [N-1:0] tvalid, tready, tlast;
  logic [N*SW-1:0] tstrb;
  logic [N*4-1:0] tuser, weight;
  logic [W-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [3:0] m_tuser;
  logic m_tlast, m_tvalid, m_tready, lnk, in_packet, flush;
  logic [1:0] sel;
  int checks = 0, failures = 0;
  int grants[6];
  int gaps_ok;

  axi_pcie_v1_06_a_axi_enhanced_tx_mport_arb dut (
    .com_iclk(clk), .com_sysrst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tstrb(tstrb), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .ch_weight(weight),
    .m_axis_tx_tdata(m_tdata), .m_axis_tx_tstrb(m_tstrb), .m_axis_tx_tlast(m_tlast),
    .m_axis_tx_tuser(m_tuser), .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tready(m_tready),
    .trn_lnk_up(lnk), .channel_sel(sel), .in_packet(in_packet), .flush_axis_tlp(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int ch, input int b);
    return {32'hC0DE0000 | 32'(ch), 32'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int b, input logic last);
    tdata[ch*W +: W] = pat(ch, b);
    tlast[ch] = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid = '0; tlast = '0; tdata = '0; tstrb = '0; tuser = '0;
    weight = 16'h1111; m_tready = 1'b1; lnk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic collect();
    int k = 0, cyc = 0, last_cyc = -1;
    gaps_ok = 1;
    for (int i = 0; i < 6; i++) grants[i] = -1;
    while (k < 6 && cyc < 40) begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        grants[k] = int'(sel);
        if (last_cyc >= 0 && cyc - last_cyc != 2) gaps_ok = 0;
        last_cyc = cyc;
        k++;
      end
      cyc++;
    end
    if (k < 6) gaps_ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tvalid = 4'hF; tlast = 4'hF; tdata = '1; m_tready = 1'b1; lnk = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_tvalid, tready, sel, in_packet, flush} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {m_tvalid, tready, sel, in_packet, flush}, 9'b0);
    end
    checks++;
    if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
  endtask

  task automatic test_single();
    do_reset();
    tvalid = 4'b0100; drive(2, 0, 1'b0);
    tstrb[2*SW +: SW] = 8'hF0; tuser[2*4 +: 4] = 4'hA;
    @(negedge clk);
    checks++;
    if (in_packet !== 1'b0 || tready !== 4'b0) begin
      failures++; $display("FAIL single_idle got=%b/%b exp=0/0000", in_packet, tready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd2 || m_tvalid !== 1'b1 || tready !== 4'b0100) begin
      failures++; $display("FAIL single_grant sel=%0d vld=%b rdy=%b exp 2/1/0100", sel, m_tvalid, tready);
    end
    checks++;
    if (m_tdata !== pat(2, 0) || m_tstrb !== 8'hF0 || m_tuser !== 4'hA) begin
      failures++; $display("FAIL single_beat0 got=%h/%h/%h exp=%h/f0/a", m_tdata, m_tstrb, m_tuser, pat(2, 0));
    end
    tick(); drive(2, 1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_tdata !== pat(2, 1) || m_tlast !== 1'b0) begin
      failures++; $display("FAIL single_beat1 got=%h last=%b exp=%h last=0", m_tdata, m_tlast, pat(2, 1));
    end
    tick(); drive(2, 2, 1'b1);
    @(negedge clk);
    checks++;
    if (m_tdata !== pat(2, 2) || m_tlast !== 1'b1) begin
      failures++; $display("FAIL single_beat2 got=%h last=%b exp=%h last=1", m_tdata, m_tlast, pat(2, 2));
    end
    tick(); drive(2, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_packet !== 1'b0 || m_tvalid !== 1'b0) begin
      failures++; $display("FAIL single_bubble got=%b/%b exp=0/0", in_packet, m_tvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (in_packet !== 1'b1 || sel !== 2'd2) begin
      failures++; $display("FAIL single_regrant got=%b sel=%0d exp=1 sel=2", in_packet, sel);
    end
    tick(); tvalid = '0;
  endtask

  task automatic test_round_robin();
    int exp[6] = '{1, 2, 3, 1, 2, 3};
    do_reset();
    for (int c = 1; c < 4; c++) drive(c, 0, 1'b1);
    tvalid = 4'b1110;
    collect();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grants[i] !== exp[i]) begin
        failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], exp[i]);
      end
    end
    checks++;
    if (gaps_ok !== 1) begin failures++; $display("FAIL rr_bubble got=%0d exp=1", gaps_ok); end
    tvalid = '0;
  endtask

  task automatic test_weights();
    int exp[6] = '{1, 1, 2, 1, 1, 2};
    do_reset();
    weight = 16'h0120;
    drive(1, 0, 1'b1); drive(2, 0, 1'b1);
    tvalid = 4'b0110;
    collect();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grants[i] !== exp[i]) begin
        failures++; $display("FAIL wrr_grant%0d got=%0d exp=%0d", i, grants[i], exp[i]);
      end
    end
    tvalid = '0;
  endtask

  task automatic test_priority();
    do_reset();
    tvalid = 4'b1000; drive(3, 0, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || m_tdata !== pat(3, 0)) begin
      failures++; $display("FAIL prio_ch3_grant sel=%0d data=%h exp 3/%h", sel, m_tdata, pat(3, 0));
    end
    tick(); drive(3, 1, 1'b0);
    drive(0, 0, 1'b1); drive(1, 0, 1'b1); drive(2, 0, 1'b1);
    tvalid = 4'b1111;
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || m_tdata !== pat(3, 1) || tready !== 4'b1000) begin
      failures++; $display("FAIL prio_hold sel=%0d data=%h rdy=%b exp 3/%h/1000", sel, m_tdata, tready, pat(3, 1));
    end
    tick(); drive(3, 2, 1'b1);
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || m_tlast !== 1'b1) begin
      failures++; $display("FAIL prio_ch3_last sel=%0d last=%b exp 3/1", sel, m_tlast);
    end
    tick(); tvalid[3] = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd0 || m_tvalid !== 1'b1) begin
      failures++; $display("FAIL prio_ch0 sel=%0d vld=%b exp 0/1", sel, m_tvalid);
    end
    tick(); tvalid[0] = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd1 || m_tdata !== pat(1, 0)) begin
      failures++; $display("FAIL prio_rr_resume sel=%0d exp=1", sel);
    end
    tick(); tvalid = '0;
  endtask

  task automatic test_link_down();
    do_reset();
    tvalid = 4'b0010; drive(1, 0, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (sel !== 2'd1 || m_tvalid !== 1'b1) begin
      failures++; $display("FAIL ld_grant sel=%0d vld=%b exp 1/1", sel, m_tvalid);
    end
    tick(); drive(1, 1, 1'b0); lnk = 1'b0;
    tick();
    for (int b = 2; b < 5; b++) begin
      drive(1, b, b == 4);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || flush !== 1'b1 || in_packet !== 1'b1 || tready !== 4'b0010) begin
        failures++;
        $display("FAIL ld_flush%0d vld=%b flush=%b pkt=%b rdy=%b exp 0/1/1/0010", b, m_tvalid, flush, in_packet, tready);
      end
      tick();
    end
    drive(1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_packet !== 1'b0 || m_tvalid !== 1'b0 || tready !== 4'b0) begin
        failures++; $display("FAIL ld_nogrant%0d pkt=%b vld=%b rdy=%b exp 0/0/0000", i, in_packet, m_tvalid, tready);
      end
      tick();
    end
    lnk = 1'b1; tvalid = '0;
  endtask

  task automatic test_backpressure();
    int b = 0, cyc = 0, got = 0;
    logic mt = 1'b1, hs;
    do_reset();
    tvalid = 4'b0100;
    while (b < 4 && cyc < 20) begin
      drive(2, b, b == 3);
      m_tready = in_packet ? mt : 1'b1;
      @(negedge clk);
      if (in_packet) begin
        checks++;
        if (tready !== {1'b0, mt, 2'b00} || m_tdata !== pat(2, b) || m_tlast !== (b == 3)) begin
          failures++;
          $display("FAIL bp_beat%0d rdy=%b data=%h last=%b exp %b/%h/%b", b, tready, m_tdata, m_tlast, {1'b0, mt, 2'b00}, pat(2, b), b == 3);
        end
      end
      hs = m_tvalid && m_tready;
      if (hs) got++;
      if (in_packet) mt = ~mt;
      tick();
      if (hs) b++;
      cyc++;
    end
    checks++;
    if (got !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
    tvalid = '0; m_tready = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    tvalid = 4'b0010; drive(1, 0, 1'b0);
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_packet !== 1'b0 || m_tvalid !== 1'b0 || tready !== 4'b0) begin
      failures++; $display("FAIL async_reset pkt=%b vld=%b rdy=%b exp 0/0/0000", in_packet, m_tvalid, tready);
    end
    rst_n = 1'b1; tvalid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_weights();
    test_priority();
    test_link_down();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
